raizing_textlayer_pb: RTL and testbench

Parametrised successor to the Raizing extra-text line renderer. It fetches one text-layer scanline per horizontal blank: per-line row select and scroll, then tilemap, then 4bpp tile ROM. It renders into an internal ping-pong line buffer and streams the finished line to the mixer on the following line. Over the previous generation it adds generics for screen, map and timing, screen flip, a busy/overrun status, and an owned double buffer. It sits between the text VRAM/select/scroll/ROM ports and the Raizing colour mixer.

---
 rtl/raizing_textlayer_pb_if.sv | 38 +++
 rtl/raizing_textlayer_pb.sv | 251 +++++++++++++++++++++++++
 tb/tb_raizing_textlayer_pb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raizing_textlayer_pb_if.sv
// Bus bundle for the Raizing text-layer line renderer: timing inputs,
// select/scroll/VRAM/ROM fetch ports, pixel output and status.
interface raizing_textlayer_pb_if;
    logic        PIXEL_CEN;
    logic [8:0]  VRENDER;
    logic [8:0]  H;
    logic        HB;
    logic        VB;
    logic        ACTIVE;
    logic        FLIP;
    logic [10:0] EXTRATEXT_PIXEL;
    logic [7:0]  TEXTSELECT_ADDR;
    logic [7:0]  TEXTSCROLL_ADDR;
    logic [15:0] TEXTSELECT_DATA;
    logic [15:0] TEXTSCROLL_DATA;
    logic [11:0] TEXTVRAM_ADDR;
    logic [15:0] TEXTVRAM_DATA;
    logic [13:0] TEXTROM_ADDR;
    logic [15:0] TEXTROM_DATA;
    logic        BUSY;
    logic        OVERRUN;

    // Video timing / memory side: drives timing and memory data, sees addresses.
    modport master (
        output PIXEL_CEN, VRENDER, H, HB, VB, ACTIVE, FLIP,
        output TEXTSELECT_DATA, TEXTSCROLL_DATA, TEXTVRAM_DATA, TEXTROM_DATA,
        input  EXTRATEXT_PIXEL, TEXTSELECT_ADDR, TEXTSCROLL_ADDR,
        input  TEXTVRAM_ADDR, TEXTROM_ADDR, BUSY, OVERRUN
    );

    // Renderer side.
    modport slave (
        input  PIXEL_CEN, VRENDER, H, HB, VB, ACTIVE, FLIP,
        input  TEXTSELECT_DATA, TEXTSCROLL_DATA, TEXTVRAM_DATA, TEXTROM_DATA,
        output EXTRATEXT_PIXEL, TEXTSELECT_ADDR, TEXTSCROLL_ADDR,
        output TEXTVRAM_ADDR, TEXTROM_ADDR, BUSY, OVERRUN
    );
endinterface

// File: rtl/raizing_textlayer_pb.sv
// Raizing extra-text layer line renderer.
// Fetches one scanline per horizontal blank (row select/scroll, tilemap,
// 4bpp tile ROM), renders into the back half of a ping-pong line buffer and
// streams the front half to the colour mixer.
// Optional screen flip is built only when RAIZING_TEXTLAYER_FLIP_EN is defined;
// otherwise FLIP is ignored and treated as 0.
module raizing_textlayer_pb #(
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240,
    parameter int unsigned TILES    = 41,
    parameter int unsigned MAP_COLS = 64,
    parameter logic [5:0]  X_OFFS   = 6'h2B,
    parameter logic [10:0] PAL_BASE = 11'h400,
    parameter int unsigned RD_LAT   = 2
) (
    input logic                   CLK96,
    input logic                   RESET96,
    raizing_textlayer_pb_if.slave bus
);

    localparam int unsigned COL_W    = $clog2(SCREEN_W);
    localparam int unsigned BUF_D    = 2 * SCREEN_W;
    localparam int unsigned BUF_AW   = $clog2(BUF_D);
    localparam int unsigned X_W      = $clog2(TILES + 1);
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MAP_MASK = MAP_COLS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SETUP,
        S_MAP,
        S_ROM0,
        S_ROM1,
        S_DRAW,
        S_NEXT
    } state_t;

    state_t             state_q;
    logic               hb_q;
    logic               bufsel_q;     // 1: upper half is front
    logic [CNT_W-1:0]   cnt_q;
    logic [X_W-1:0]     x_q;
    logic [2:0]         tx_q;
    logic [5:0]         startx_q;
    logic [2:0]         fine_q;
    logic [4:0]         row_q;
    logic [2:0]         sub_q;
    logic [5:0]         pal_q;
    logic [31:0]        word_q;
    logic [7:0]         line_addr_q;
    logic [11:0]        vram_addr_q;
    logic [13:0]        rom_addr_q;
    logic [10:0]        pix_q;
    logic               busy_q;
    logic               overrun_q;

    logic [10:0]        line_mem [BUF_D];

    logic               line_start_c;
    logic [7:0]         ly_c;
    logic [8:0]         off_c;
    logic [5:0]         startx_c;
    logic [9:0]         sx_c;
    logic               in_range_c;
    logic [COL_W-1:0]   col_c;
    logic [4:0]         shift_c;
    logic [3:0]         nib_c;
    logic [10:0]        pix_data_c;
    logic               wr_en_c;
    logic [BUF_AW-1:0]  wr_idx_c;
    logic [BUF_AW-1:0]  rd_idx_c;
    logic               unused_bits;

`ifdef RAIZING_TEXTLAYER_FLIP_EN
    logic               flip_q;
`endif

    // Tilemap word address for tile slot x of the current row, wrapping in the map width.
    function automatic logic [11:0] map_addr(input logic [4:0] row,
                                             input logic [X_W-1:0] x,
                                             input logic [5:0] sx0);
        logic [31:0] col;
        col = (32'(x) + 32'(sx0)) & 32'(MAP_MASK);
        return 12'(32'(row) * MAP_COLS + col);
    endfunction

    // Line start on HB falling edge, outside vblank or on line 0.
    assign line_start_c = hb_q && !bus.HB && (!bus.VB || (bus.VRENDER == 9'd0));

`ifdef RAIZING_TEXTLAYER_FLIP_EN
    assign ly_c = bus.FLIP ? (8'(SCREEN_H - 1) - bus.VRENDER[7:0]) : bus.VRENDER[7:0];
    assign unused_bits = ^{bus.TEXTSELECT_DATA[15:8], bus.TEXTSCROLL_DATA[15:9]};
`else
    assign ly_c = bus.VRENDER[7:0];
    assign unused_bits = ^{bus.TEXTSELECT_DATA[15:8], bus.TEXTSCROLL_DATA[15:9], bus.FLIP};
`endif

    // Only the low 9 bits of scroll+offset feed the tile/fine split.
    assign off_c    = bus.TEXTSCROLL_DATA[8:0] + 9'(X_OFFS);
    assign startx_c = off_c[8:3] & 6'(MAP_MASK);

    // Draw-phase pixel position, nibble select and palette value.
    assign sx_c       = 10'({x_q, tx_q}) - 10'(fine_q);
    assign in_range_c = !sx_c[9] && (sx_c < 10'(SCREEN_W));
`ifdef RAIZING_TEXTLAYER_FLIP_EN
    assign col_c = flip_q ? (COL_W'(SCREEN_W - 1) - COL_W'(sx_c)) : COL_W'(sx_c);
`else
    assign col_c = COL_W'(sx_c);
`endif
    assign shift_c    = 5'd28 - {tx_q, 2'b00};
    assign nib_c      = 4'(word_q >> shift_c);
    assign pix_data_c = (nib_c == 4'd0) ? 11'd0
                                        : PAL_BASE + 11'({pal_q, 4'b0000}) + 11'(nib_c);

    // Back half is written, front half is read.
    assign wr_en_c  = (state_q == S_DRAW) && in_range_c && !line_start_c;
    assign wr_idx_c = bufsel_q ? BUF_AW'(col_c) : (BUF_AW'(SCREEN_W) + BUF_AW'(col_c));
    assign rd_idx_c = bufsel_q ? (BUF_AW'(SCREEN_W) + BUF_AW'(bus.H)) : BUF_AW'(bus.H);

    // Fetch/render sequencer with RD_LAT wait after each address issue.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q     <= S_IDLE;
            hb_q        <= 1'b0;
            bufsel_q    <= 1'b0;
            cnt_q       <= '0;
            x_q         <= '0;
            tx_q        <= '0;
            startx_q    <= '0;
            fine_q      <= '0;
            row_q       <= '0;
            sub_q       <= '0;
            pal_q       <= '0;
            word_q      <= '0;
            line_addr_q <= '0;
            vram_addr_q <= '0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RAIZING_TEXTLAYER_FLIP_EN
            flip_q      <= 1'b0;
`endif
        end else begin
            hb_q      <= bus.HB;
            overrun_q <= 1'b0;
            if (line_start_c) begin
                overrun_q   <= (state_q != S_IDLE);
                bufsel_q    <= ~bufsel_q;
`ifdef RAIZING_TEXTLAYER_FLIP_EN
                flip_q      <= bus.FLIP;
`endif
                line_addr_q <= ly_c;
                cnt_q       <= CNT_W'(RD_LAT);
                busy_q      <= 1'b1;
                state_q     <= S_SEL;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_SEL: begin
                        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                        else             state_q <= S_SETUP;
                    end
                    S_SETUP: begin
                        startx_q    <= startx_c;
                        fine_q      <= off_c[2:0];
                        row_q       <= bus.TEXTSELECT_DATA[7:3];
                        sub_q       <= bus.TEXTSELECT_DATA[2:0];
                        x_q         <= '0;
                        vram_addr_q <= map_addr(bus.TEXTSELECT_DATA[7:3], X_W'(0), startx_c);
                        cnt_q       <= CNT_W'(RD_LAT);
                        state_q     <= S_MAP;
                    end
                    S_MAP: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            pal_q      <= bus.TEXTVRAM_DATA[15:10];
                            rom_addr_q <= {bus.TEXTVRAM_DATA[9:0], 4'b0000} + 14'({sub_q, 1'b0});
                            cnt_q      <= CNT_W'(RD_LAT);
                            state_q    <= S_ROM0;
                        end
                    end
                    S_ROM0: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            word_q[31:16] <= bus.TEXTROM_DATA;
                            rom_addr_q    <= rom_addr_q + 14'd1;
                            cnt_q         <= CNT_W'(RD_LAT);
                            state_q       <= S_ROM1;
                        end
                    end
                    S_ROM1: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            word_q[15:0] <= bus.TEXTROM_DATA;
                            tx_q         <= '0;
                            state_q      <= S_DRAW;
                        end
                    end
                    S_DRAW: begin
                        tx_q <= tx_q + 3'd1;
                        if (tx_q == 3'd7) state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        if ((32'(x_q) + 32'd1) < TILES) begin
                            x_q         <= x_q + X_W'(1);
                            vram_addr_q <= map_addr(row_q, x_q + X_W'(1), startx_q);
                            cnt_q       <= CNT_W'(RD_LAT);
                            state_q     <= S_MAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Line buffer write port (contents deliberately not reset).
    always_ff @(posedge CLK96) begin
        if (wr_en_c) line_mem[wr_idx_c] <= pix_data_c;
    end

    // Pixel output register: front-buffer read on pixel enable, 0 past the visible width.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            pix_q <= '0;
        end else if (bus.PIXEL_CEN && bus.ACTIVE) begin
            pix_q <= (bus.H < 9'(SCREEN_W)) ? line_mem[rd_idx_c] : 11'd0;
        end
    end

    assign bus.EXTRATEXT_PIXEL = pix_q;
    assign bus.TEXTSELECT_ADDR = line_addr_q;
    assign bus.TEXTSCROLL_ADDR = line_addr_q;
    assign bus.TEXTVRAM_ADDR   = vram_addr_q;
    assign bus.TEXTROM_ADDR    = rom_addr_q;
    assign bus.BUSY            = busy_q;
    assign bus.OVERRUN         = overrun_q;

endmodule

// File: tb/tb_raizing_textlayer_pb.sv
// Bench for raizing_textlayer_pb: memory models with 2-cycle read latency,
// a pixel-centric reference model and a pixel scoreboard.
module tb_raizing_textlayer_pb;

`ifdef RAIZING_TEXTLAYER_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    raizing_textlayer_pb_if bus ();

    raizing_textlayer_pb dut (
        .CLK96   (clk),
        .RESET96 (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] sel_mem [256];
    logic [15:0] scr_mem [256];
    logic [15:0] vram    [4096];
    logic [15:0] rom     [16384];

    logic [15:0] sel_p1, sel_p2, scr_p1, scr_p2, vr_p1, vr_p2, rom_p1, rom_p2;

    // Memories answer two cycles after an address change.
    always @(posedge clk) begin
        sel_p1 <= sel_mem[bus.TEXTSELECT_ADDR];
        sel_p2 <= sel_p1;
        scr_p1 <= scr_mem[bus.TEXTSCROLL_ADDR];
        scr_p2 <= scr_p1;
        vr_p1  <= vram[bus.TEXTVRAM_ADDR];
        vr_p2  <= vr_p1;
        rom_p1 <= rom[bus.TEXTROM_ADDR];
        rom_p2 <= rom_p1;
    end

    assign bus.TEXTSELECT_DATA = sel_p2;
    assign bus.TEXTSCROLL_DATA = scr_p2;
    assign bus.TEXTVRAM_DATA   = vr_p2;
    assign bus.TEXTROM_DATA    = rom_p2;

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q [$];

    typedef struct {
        logic [8:0]  vr;
        logic        fl;
        logic [15:0] sel;
        logic [15:0] scr;
        logic [7:0]  ly_on;
        logic [7:0]  ly_off;
        logic [11:0] vram0;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: derive each screen pixel independently from the memories.
    function automatic logic [10:0] model_px(input int col, input logic [7:0] ly, input logic fl);
        logic [15:0] off, sel, w, rw;
        int startx, fine, row, sub, sx, pos, x, tx, va, code, pal, ra, n;
        sel    = sel_mem[ly];
        off    = scr_mem[ly] + 16'h002B;
        startx = int'(off[8:3]) & 63;
        fine   = int'(off[2:0]);
        row    = int'(sel[7:3]);
        sub    = int'(sel[2:0]);
        sx     = fl ? (319 - col) : col;
        pos    = sx + fine;
        x      = pos / 8;
        tx     = pos % 8;
        va     = row * 64 + ((x + startx) % 64);
        w      = vram[va];
        code   = int'(w[9:0]);
        pal    = int'(w[15:10]);
        ra     = code * 16 + sub * 2 + tx / 4;
        rw     = rom[ra];
        n      = (int'(rw) >> (4 * (3 - (tx % 4)))) & 15;
        return (n == 0) ? 11'd0 : 11'(1024 + pal * 16 + n);
    endfunction

    task automatic start_line(input logic [8:0] vr, input logic fl, input logic vb);
        @(negedge clk);
        bus.VRENDER = vr;
        bus.FLIP    = fl;
        bus.VB      = vb;
        bus.HB      = 1'b1;
        @(negedge clk);
        bus.HB = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY === 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("line_done_busy", int'(bus.BUSY), 0);
    endtask

    task automatic wait_vram(input logic [11:0] req);
        int n = 0;
        while (bus.TEXTVRAM_ADDR !== req && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_vram_addr", int'(bus.TEXTVRAM_ADDR), int'(req));
    endtask

    task automatic wait_rom(input logic [13:0] req);
        int n = 0;
        while (bus.TEXTROM_ADDR !== req && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_rom_addr", int'(bus.TEXTROM_ADDR), int'(req));
    endtask

    // One display pixel: expectation queued at drive, popped when the output register updates.
    task automatic show(input string nm, input logic [8:0] h, input logic act,
                        input logic cen, input logic [10:0] e);
        logic [10:0] want;
        @(negedge clk);
        bus.H         = h;
        bus.ACTIVE    = act;
        bus.PIXEL_CEN = cen;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(nm, int'(bus.EXTRATEXT_PIXEL), int'(want));
    endtask

    task automatic show_line(input logic [7:0] ly, input logic fl);
        for (int c = 0; c < 320; c++) show("line_pixel", 9'(c), 1'b1, 1'b1, model_px(c, ly, fl));
        @(negedge clk);
        bus.PIXEL_CEN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ly;
        logic        fe;
        logic [15:0] w;
        logic [2:0]  sb;
        logic [10:0] h5;

        for (int i = 0; i < 256; i++) begin
            sel_mem[i] = 16'($urandom);
            scr_mem[i] = 16'($urandom);
        end
        for (int i = 0; i < 4096; i++)  vram[i] = 16'($urandom);
        for (int i = 0; i < 16384; i++) rom[i]  = 16'($urandom);
        vram[12'h045] = 16'h0C01;
        rom[16]       = 16'h1230;
        rom[17]       = 16'h0000;

        vecs[0] = '{9'd0,   1'b0, 16'h0008, 16'h0000, 8'd0,   8'd0,   12'h045};
        vecs[1] = '{9'd10,  1'b1, 16'h00F3, 16'h0105, 8'd229, 8'd10,  12'h7A6};
        vecs[2] = '{9'd100, 1'b0, 16'h007D, 16'hFFD5, 8'd100, 8'd100, 12'h3C0};
        vecs[3] = '{9'd239, 1'b1, 16'h00FF, 16'h01F0, 8'd0,   8'd239, 12'h7C3};

        rst           = 1'b1;
        bus.PIXEL_CEN = 1'b0;
        bus.VRENDER   = 9'd0;
        bus.H         = 9'd0;
        bus.HB        = 1'b0;
        bus.VB        = 1'b0;
        bus.ACTIVE    = 1'b0;
        bus.FLIP      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel",    int'(bus.EXTRATEXT_PIXEL), 0);
        check("rst_busy",     int'(bus.BUSY), 0);
        check("rst_overrun",  int'(bus.OVERRUN), 0);
        check("rst_sel_addr", int'(bus.TEXTSELECT_ADDR), 0);
        check("rst_vram",     int'(bus.TEXTVRAM_ADDR), 0);
        check("rst_rom",      int'(bus.TEXTROM_ADDR), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table: render a line, swap it to the front, stream it out and compare.
        for (int i = 0; i < 4; i++) begin
            ly = FLIP_ON ? vecs[i].ly_on : vecs[i].ly_off;
            fe = FLIP_ON ? vecs[i].fl : 1'b0;
            sel_mem[ly] = vecs[i].sel;
            scr_mem[ly] = vecs[i].scr;
            start_line(vecs[i].vr, vecs[i].fl, 1'b0);
            check("start_busy",    int'(bus.BUSY), 1);
            check("start_sel",     int'(bus.TEXTSELECT_ADDR), int'(ly));
            check("start_scroll",  int'(bus.TEXTSCROLL_ADDR), int'(ly));
            check("start_overrun", int'(bus.OVERRUN), 0);
            wait_vram(vecs[i].vram0);
            w  = vram[vecs[i].vram0];
            sb = vecs[i].sel[2:0];
            wait_rom(14'(int'(w[9:0]) * 16 + int'(sb) * 2));
            wait_idle();
            start_line(vecs[i].vr, vecs[i].fl, 1'b0);
            show_line(ly, fe);
            wait_idle();
        end

        // Off-screen H, inactive display and no pixel enable.
        ly = FLIP_ON ? vecs[3].ly_on : vecs[3].ly_off;
        fe = FLIP_ON ? vecs[3].fl : 1'b0;
        h5 = model_px(5, ly, fe);
        show("pix_h320",      9'd320, 1'b1, 1'b1, 11'd0);
        show("pix_h511",      9'd511, 1'b1, 1'b1, 11'd0);
        show("pix_h5",        9'd5,   1'b1, 1'b1, h5);
        show("hold_inactive", 9'd400, 1'b0, 1'b1, h5);
        show("hold_no_cen",   9'd400, 1'b1, 1'b0, h5);
        show("pix_h319",      9'd319, 1'b1, 1'b1, model_px(319, ly, fe));

        // Overrun: restart line 21 while line 20 is still being fetched.
        sel_mem[20] = 16'h0029; scr_mem[20] = 16'h0013;
        sel_mem[21] = 16'h00B2; scr_mem[21] = 16'h0077;
        start_line(9'd20, 1'b0, 1'b0);
        wait_idle();
        start_line(9'd21, 1'b0, 1'b0);
        check("no_overrun_idle", int'(bus.OVERRUN), 0);
        wait_idle();
        start_line(9'd20, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        check("busy_midline", int'(bus.BUSY), 1);
        start_line(9'd21, 1'b0, 1'b0);
        check("overrun_pulse", int'(bus.OVERRUN), 1);
        check("overrun_busy",  int'(bus.BUSY), 1);
        check("overrun_sel",   int'(bus.TEXTSELECT_ADDR), 21);
        @(posedge clk);
        #1;
        check("overrun_single", int'(bus.OVERRUN), 0);
        show_line(8'd20, 1'b0);
        wait_idle();

        // HB fall inside vblank on a non-zero line is not a start.
        start_line(9'd5, 1'b0, 1'b1);
        check("vb_no_start", int'(bus.BUSY), 0);

        // Reset in the middle of a line fetch.
        start_line(9'd20, 1'b0, 1'b0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pixel",   int'(bus.EXTRATEXT_PIXEL), 0);
        check("midrst_busy",    int'(bus.BUSY), 0);
        check("midrst_overrun", int'(bus.OVERRUN), 0);
        check("midrst_sel",     int'(bus.TEXTSELECT_ADDR), 0);
        check("midrst_vram",    int'(bus.TEXTVRAM_ADDR), 0);
        check("midrst_rom",     int'(bus.TEXTROM_ADDR), 0);
        @(negedge clk);
        rst = 1'b0;
        sel_mem[0] = 16'h0000;
        start_line(9'd0, 1'b0, 1'b1);
        check("post_rst_busy", int'(bus.BUSY), 1);
        check("post_rst_sel",  int'(bus.TEXTSELECT_ADDR), 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
